fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RV32 pipeline.
- Owns the PC and addresses instruction memory (combinational read, same-cycle data).
- Registers {instruction, pc, pc+4, valid} for the decode stage; the IF/ID instruction drives the control unit's `instruction` input.
- Handles load-use stall, taken-branch/jump redirect with flush, halt on illegal instruction, and a fetched-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- o_imem_addr  out  32  instruction memory address (= current PC).
- i_imem_rdata  in  32  instruction word at o_imem_addr, same cycle.
- i_stall  in  1  hazard unit: hold PC and IF/ID.
- i_redirect  in  1  EX stage: branch taken or jump.
- i_redirect_pc  in  32  redirect target.
- i_halt  in  1  decode reports illegal opcode (inverse of o_inst_vld, qualified by o_id_valid).
- o_id_inst  out  32  IF/ID instruction.
- o_id_pc  out  32  IF/ID PC.
- o_id_pc4  out  32  IF/ID PC+4.
- o_id_valid  out  1  IF/ID holds a real instruction.
- o_misalign  out  1  one-cycle pulse: redirect target had bits[1:0] != 0.
- o_halted  out  1  FSM in HALT.
- o_fetch_cnt  out  32  valid instructions delivered to IF/ID.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect) forces:
  - PC=RESET_PC, state=BOOT.
  - o_id_inst=NOP_INST, o_id_pc=0, o_id_pc4=0, o_id_valid=0.
  - o_misalign=0, o_halted=0, o_fetch_cnt=0.
- o_imem_addr = PC combinationally at all times.
- FSM states:
  - BOOT: one cycle; IF/ID stays bubble; PC unchanged; next state RUN unconditionally.
  - RUN: normal fetch. RUN->HALT when i_halt=1.
  - HALT: PC frozen; IF/ID forced to bubble every cycle; o_halted=1; inputs ignored; exit only via reset.
- Per-edge priority in RUN: i_halt > i_redirect > i_stall > normal.
  - i_halt: enter HALT; IF/ID <= bubble; PC held.
  - i_redirect (overrides i_stall in the same cycle):
    - PC <= {i_redirect_pc[31:2],2'b00}.
    - IF/ID <= bubble (NOP_INST, valid=0, pc/pc4 held).
    - o_misalign <= |i_redirect_pc[1:0], otherwise 0.
  - i_stall only: PC and all IF/ID fields hold their values; counter holds.
  - Normal:
    - IF/ID <= {i_imem_rdata, PC, PC+4, valid=1}.
    - PC <= PC+4.
    - o_fetch_cnt += 1.
- Arithmetic: PC+4 is 32-bit modulo. From 32'hFFFF_FFFC, PC wraps to 0 and o_id_pc4=0; no flag.
- o_fetch_cnt: increments only on the normal capture; wraps 32'hFFFF_FFFF -> 0 silently.
- o_misalign: registered; deasserts next cycle unless another misaligned redirect occurs.
- PC[1:0] is always 00.
- No internal hazard detection; i_stall and i_redirect are trusted to be registered-stage signals.

Test Plan:
- Reset release, RESET_PC=0, imem returns 32'h00A00093 at 0 and 32'h00100113 at 4:
  - BOOT cycle: o_id_valid=0.
  - Next edge: o_id_inst=00A00093, o_id_pc=0, o_id_pc4=4, o_fetch_cnt=1.
  - Following edge: o_id_pc=4, o_fetch_cnt=2.
- i_stall=1 for 3 cycles with PC=8: o_imem_addr stays 8, IF/ID unchanged, o_fetch_cnt unchanged. On release, capture resumes at PC=8.
- i_redirect=1, i_redirect_pc=32'h0000_0100, with i_stall=1 in the same cycle: next PC=0x100, o_id_inst=00000013, o_id_valid=0, o_misalign=0. Next edge: o_id_pc=0x100.
- i_redirect_pc=32'h0000_0102: PC=0x100, o_misalign high exactly one cycle.
- i_halt=1 with i_redirect=1: o_halted=1, PC frozen, o_id_valid=0 for 10 cycles. Assert i_rst mid-halt: all outputs return to reset values, then BOOT->RUN.
- PC preloaded via redirect to 32'hFFFF_FFFC, then normal fetch: o_id_pc=FFFFFFFC, o_id_pc4=0, next o_imem_addr=0. Counter forced near 32'hFFFF_FFFF wraps to 0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Signal bundle between the IF stage and its environment: instruction memory,
// hazard/redirect controls from later stages, and the IF/ID register outputs.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        misalign;
  logic        halted;
  logic [31:0] fetch_cnt;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  redirect,
    input  redirect_pc,
    input  halt,
    output id_inst,
    output id_pc,
    output id_pc4,
    output id_valid,
    output misalign,
    output halted,
    output fetch_cnt
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output redirect,
    output redirect_pc,
    output halt,
    input  id_inst,
    input  id_pc,
    input  id_pc4,
    input  id_valid,
    input  misalign,
    input  halted,
    input  fetch_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32 IF stage with IF/ID pipeline register: PC ownership, stall, redirect
// with flush, halt-until-reset and a count of delivered instructions.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    misalign_d = 1'b0;
    cnt_d      = cnt_q;
    unique case (state_q)
      StBoot: begin
        state_d    = StRun;
        id_inst_d  = NOP_INST;
        id_valid_d = 1'b0;
      end
      StRun: begin
        if (bus.halt) begin
          state_d    = StHalt;
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
        end else if (bus.redirect) begin
          // Target is force-aligned; the low bits only raise the pulse.
          pc_d       = {bus.redirect_pc[31:2], 2'b00};
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
          misalign_d = |bus.redirect_pc[1:0];
        end else if (!bus.stall) begin
          pc_d       = pc_plus4;
          id_inst_d  = bus.imem_rdata;
          id_pc_d    = pc_q;
          id_pc4_d   = pc_plus4;
          id_valid_d = 1'b1;
          cnt_d      = cnt_q + 32'd1;
        end
      end
      StHalt: begin
        id_inst_d  = NOP_INST;
        id_valid_d = 1'b0;
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= 32'd0;
      id_pc4_q   <= 32'd0;
      id_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.id_inst   = id_inst_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_pc4    = id_pc4_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.misalign  = misalign_q;
  assign bus.halted    = (state_q == StHalt);
  assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset/boot, stall, redirect, misalign,
// halt with mid-halt reset, and PC/counter wrap.
module tb_fetch_stage;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: two fixed words, otherwise a tagged address.
  always_comb begin
    if (bus.imem_addr == 32'h0)      bus.imem_rdata = 32'h00A0_0093;
    else if (bus.imem_addr == 32'h4) bus.imem_rdata = 32'h0010_0113;
    else                             bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt = 1'b0;
    step();
    n_vec++;
    if (bus.imem_addr !== 32'h0 || bus.id_inst !== 32'h13 || bus.id_pc !== 32'h0 ||
        bus.id_pc4 !== 32'h0 || bus.id_valid !== 1'b0 || bus.misalign !== 1'b0 ||
        bus.halted !== 1'b0 || bus.fetch_cnt !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: addr=%h inst=%h pc=%h pc4=%h v=%b mis=%b h=%b cnt=%0d",
               bus.imem_addr, bus.id_inst, bus.id_pc, bus.id_pc4, bus.id_valid,
               bus.misalign, bus.halted, bus.fetch_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_vec++;
    if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL boot_bubble: valid=%b addr=%h, need 0 / 00000000",
               bus.id_valid, bus.imem_addr);
    end
    step();
    n_vec++;
    if (bus.id_inst !== 32'h00A0_0093 || bus.id_pc !== 32'h0 || bus.id_pc4 !== 32'h4 ||
        bus.id_valid !== 1'b1 || bus.fetch_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL first_fetch: inst=%h pc=%h pc4=%h v=%b cnt=%0d, need 00a00093/0/4/1/1",
               bus.id_inst, bus.id_pc, bus.id_pc4, bus.id_valid, bus.fetch_cnt);
    end
    step();
    n_vec++;
    if (bus.id_inst !== 32'h0010_0113 || bus.id_pc !== 32'h4 || bus.fetch_cnt !== 32'd2 ||
        bus.imem_addr !== 32'h8) begin
      n_bad++;
      $display("FAIL second_fetch: inst=%h pc=%h cnt=%0d addr=%h, need 00100113/4/2/8",
               bus.id_inst, bus.id_pc, bus.fetch_cnt, bus.imem_addr);
    end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (bus.imem_addr !== 32'h8 || bus.id_pc !== 32'h4 || bus.id_inst !== 32'h0010_0113 ||
          bus.id_valid !== 1'b1 || bus.fetch_cnt !== 32'd2) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: addr=%h pc=%h inst=%h v=%b cnt=%0d, need 8/4/00100113/1/2",
                 i, bus.imem_addr, bus.id_pc, bus.id_inst, bus.id_valid, bus.fetch_cnt);
      end
    end
    bus.stall = 1'b0;
    step();
    n_vec++;
    if (bus.id_pc !== 32'h8 || bus.id_inst !== (32'h8 ^ 32'hA5A5_0000) ||
        bus.fetch_cnt !== 32'd3 || bus.imem_addr !== 32'hC) begin
      n_bad++;
      $display("FAIL stall_release: pc=%h inst=%h cnt=%0d addr=%h, need 8/a5a50008/3/c",
               bus.id_pc, bus.id_inst, bus.fetch_cnt, bus.imem_addr);
    end
  endtask

  task automatic test_redirect();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    bus.stall = 1'b1;
    step();
    n_vec++;
    if (bus.imem_addr !== 32'h100 || bus.id_inst !== 32'h13 || bus.id_valid !== 1'b0 ||
        bus.misalign !== 1'b0 || bus.id_pc !== 32'h8 || bus.fetch_cnt !== 32'd3) begin
      n_bad++;
      $display("FAIL redirect_flush: addr=%h inst=%h v=%b mis=%b pc=%h cnt=%0d, need 100/13/0/0/8/3",
               bus.imem_addr, bus.id_inst, bus.id_valid, bus.misalign, bus.id_pc,
               bus.fetch_cnt);
    end
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    step();
    n_vec++;
    if (bus.id_pc !== 32'h100 || bus.id_pc4 !== 32'h104 || bus.id_valid !== 1'b1 ||
        bus.fetch_cnt !== 32'd4) begin
      n_bad++;
      $display("FAIL redirect_target: pc=%h pc4=%h v=%b cnt=%0d, need 100/104/1/4",
               bus.id_pc, bus.id_pc4, bus.id_valid, bus.fetch_cnt);
    end
  endtask

  task automatic test_misalign();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0102;
    step();
    n_vec++;
    if (bus.imem_addr !== 32'h100 || bus.misalign !== 1'b1 || bus.id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_pulse: addr=%h mis=%b v=%b, need 100/1/0",
               bus.imem_addr, bus.misalign, bus.id_valid);
    end
    bus.redirect = 1'b0;
    step();
    n_vec++;
    if (bus.misalign !== 1'b0 || bus.id_pc !== 32'h100 || bus.fetch_cnt !== 32'd5) begin
      n_bad++;
      $display("FAIL misalign_clear: mis=%b pc=%h cnt=%0d, need 0/100/5",
               bus.misalign, bus.id_pc, bus.fetch_cnt);
    end
  endtask

  task automatic test_halt();
    bus.halt = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    step();
    n_vec++;
    if (bus.halted !== 1'b1 || bus.imem_addr !== 32'h104 || bus.id_valid !== 1'b0 ||
        bus.id_inst !== 32'h13) begin
      n_bad++;
      $display("FAIL halt_enter: h=%b addr=%h v=%b inst=%h, need 1/104/0/13",
               bus.halted, bus.imem_addr, bus.id_valid, bus.id_inst);
    end
    bus.halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.stall = i[0];
      bus.redirect = i[1];
      step();
      n_vec++;
      if (bus.halted !== 1'b1 || bus.imem_addr !== 32'h104 || bus.id_valid !== 1'b0 ||
          bus.fetch_cnt !== 32'd5) begin
        n_bad++;
        $display("FAIL halt_hold[%0d]: h=%b addr=%h v=%b cnt=%0d, need 1/104/0/5",
                 i, bus.halted, bus.imem_addr, bus.id_valid, bus.fetch_cnt);
      end
    end
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.halted !== 1'b0 || bus.imem_addr !== 32'h0 || bus.fetch_cnt !== 32'd0 ||
        bus.id_valid !== 1'b0 || bus.id_inst !== 32'h13 || bus.id_pc !== 32'h0 ||
        bus.id_pc4 !== 32'h0 || bus.misalign !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_reset: h=%b addr=%h cnt=%0d v=%b inst=%h pc=%h pc4=%h mis=%b",
               bus.halted, bus.imem_addr, bus.fetch_cnt, bus.id_valid, bus.id_inst,
               bus.id_pc, bus.id_pc4, bus.misalign);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_vec++;
    if (bus.id_valid !== 1'b0 || bus.halted !== 1'b0) begin
      n_bad++;
      $display("FAIL reboot_bubble: v=%b h=%b, need 0/0", bus.id_valid, bus.halted);
    end
    step();
    n_vec++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.fetch_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL reboot_fetch: v=%b pc=%h cnt=%0d, need 1/0/1",
               bus.id_valid, bus.id_pc, bus.fetch_cnt);
    end
  endtask

  task automatic test_wrap();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    n_vec++;
    if (bus.imem_addr !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL wrap_preload: addr=%h, need fffffffc", bus.imem_addr);
    end
    bus.redirect = 1'b0;
    step();
    n_vec++;
    if (bus.id_pc !== 32'hFFFF_FFFC || bus.id_pc4 !== 32'h0 || bus.imem_addr !== 32'h0 ||
        bus.fetch_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL pc_wrap: pc=%h pc4=%h addr=%h cnt=%0d, need fffffffc/0/0/2",
               bus.id_pc, bus.id_pc4, bus.imem_addr, bus.fetch_cnt);
    end
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    step();
    n_vec++;
    if (bus.fetch_cnt !== 32'h0 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h00A0_0093) begin
      n_bad++;
      $display("FAIL cnt_wrap: cnt=%h pc=%h inst=%h, need 0/0/00a00093",
               bus.fetch_cnt, bus.id_pc, bus.id_inst);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_stall();
    test_redirect();
    test_misalign();
    test_halt();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, need completion");
    $fatal(1);
  end
endmodule
